// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter sharing the single GPR write port between the execute (port 0)
// and load (port 1) producers, each with a one-entry holding buffer.
module gpr_wb_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RfAddrWidth = 5,
  parameter int unsigned NbGpr       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb0_valid_i,
  input  logic [RfAddrWidth-1:0] wb0_rd_i,
  input  logic [DataWidth-1:0]   wb0_val_i,
  output logic                   wb0_ready_o,
  input  logic                   wb1_valid_i,
  input  logic [RfAddrWidth-1:0] wb1_rd_i,
  input  logic [DataWidth-1:0]   wb1_val_i,
  output logic                   wb1_ready_o,
  output logic [RfAddrWidth-1:0] rd_o,
  output logic [DataWidth-1:0]   rd_val_o,
  output logic                   rd_valid_o,
  output logic [NbGpr-1:0]       pending_o
);

  typedef enum logic [1:0] {
    AGE_TIE      = 2'd0,
    AGE_P0_OLDER = 2'd1,
    AGE_P1_OLDER = 2'd2
  } age_e;

  logic                   buf0_valid;
  logic [RfAddrWidth-1:0] buf0_rd;
  logic [DataWidth-1:0]   buf0_val;
  logic                   buf1_valid;
  logic [RfAddrWidth-1:0] buf1_rd;
  logic [DataWidth-1:0]   buf1_val;

  age_e age_q;
  age_e age_d;
  logic rr_q;
  logic rr_d;

  logic elig0, elig1;
  logic drop0, drop1;
  logic grant0, grant1;
  logic tie_grant;
  logic retire0, retire1;
  logic load0, load1;
  logic arb_load0, arb_load1;
  logic stay0, stay1;

  // Grant is purely a function of registered state.
  always_comb begin
    elig0     = buf0_valid && (buf0_rd != '0);
    elig1     = buf1_valid && (buf1_rd != '0);
    drop0     = buf0_valid && (buf0_rd == '0);
    drop1     = buf1_valid && (buf1_rd == '0);
    grant0    = 1'b0;
    grant1    = 1'b0;
    tie_grant = 1'b0;
    if (elig0 && elig1) begin
      case (age_q)
        AGE_P0_OLDER: grant0 = 1'b1;
        AGE_P1_OLDER: grant1 = 1'b1;
        default: begin
          tie_grant = 1'b1;
          if (rr_q) begin
            grant1 = 1'b1;
          end else begin
            grant0 = 1'b1;
          end
        end
      endcase
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    retire0 = grant0 || drop0;
    retire1 = grant1 || drop1;
  end

  always_comb begin
    wb0_ready_o = !rst_i && (!buf0_valid || retire0);
    wb1_ready_o = !rst_i && (!buf1_valid || retire1);
    load0       = wb0_valid_i && wb0_ready_o;
    load1       = wb1_valid_i && wb1_ready_o;
    stay0       = buf0_valid && !retire0;
    stay1       = buf1_valid && !retire1;
  end

  // x0 loads are dropped unseen, so they are kept out of the age bookkeeping.
  always_comb begin
    arb_load0 = load0 && (wb0_rd_i != '0);
    arb_load1 = load1 && (wb1_rd_i != '0);
    age_d     = age_q;
    if (arb_load0 && arb_load1) begin
      age_d = AGE_TIE;
    end else if (arb_load0) begin
      age_d = stay1 ? AGE_P1_OLDER : AGE_TIE;
    end else if (arb_load1) begin
      age_d = stay0 ? AGE_P0_OLDER : AGE_TIE;
    end
    rr_d = tie_grant ? ~rr_q : rr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf0_valid <= 1'b0;
      buf0_rd    <= '0;
      buf0_val   <= '0;
      buf1_valid <= 1'b0;
      buf1_rd    <= '0;
      buf1_val   <= '0;
      age_q      <= AGE_TIE;
      rr_q       <= 1'b0;
    end else begin
      if (load0) begin
        buf0_valid <= 1'b1;
        buf0_rd    <= wb0_rd_i;
        buf0_val   <= wb0_val_i;
      end else if (retire0) begin
        buf0_valid <= 1'b0;
      end
      if (load1) begin
        buf1_valid <= 1'b1;
        buf1_rd    <= wb1_rd_i;
        buf1_val   <= wb1_val_i;
      end else if (retire1) begin
        buf1_valid <= 1'b0;
      end
      age_q <= age_d;
      rr_q  <= rr_d;
    end
  end

  // Outputs are forced low during reset so a buffered write is never committed.
  always_comb begin
    rd_valid_o = 1'b0;
    rd_o       = '0;
    rd_val_o   = '0;
    if (!rst_i) begin
      if (grant0) begin
        rd_valid_o = 1'b1;
        rd_o       = buf0_rd;
        rd_val_o   = buf0_val;
      end else if (grant1) begin
        rd_valid_o = 1'b1;
        rd_o       = buf1_rd;
        rd_val_o   = buf1_val;
      end
    end
  end

  always_comb begin
    pending_o = '0;
    if (!rst_i) begin
      for (int unsigned i = 1; i < NbGpr; i++) begin
        pending_o[i] = (buf0_valid && (buf0_rd == RfAddrWidth'(i))) ||
                       (buf1_valid && (buf1_rd == RfAddrWidth'(i)));
      end
    end
  end

endmodule
